// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: ball motion, paddle bounces, scoring and serve FSM.
// The ball advances STEP px per axis on every strobe while in play.
module pong_ball_ctrl #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int BALL_SIZE  = 8,
   parameter int PADDLE_W   = 8,
   parameter int PADDLE_H   = 64,
   parameter int PADDLE_X_L = 16,
   parameter int PADDLE_X_R = 616,
   parameter int STEP       = 2,
   parameter int HOLD_TICKS = 30,
   parameter int WIN_SCORE  = 9
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       strobe_i,
   input  logic       serve_i,
   input  logic [9:0] paddle_l_y_i,
   input  logic [9:0] paddle_r_y_i,
   output logic [9:0] ball_x_o,
   output logic [9:0] ball_y_o,
   output logic [3:0] score_l_o,
   output logic [3:0] score_r_o,
   output logic       goal_o,
   output logic       game_over_o
);

   typedef enum logic [1:0] {IDLE, PLAY, GOAL, OVER} state_t;

   localparam int HW = $clog2(HOLD_TICKS + 1);

   localparam logic [10:0] XC     = 11'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [10:0] YC     = 11'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [10:0] XMAX   = 11'(SCREEN_W - BALL_SIZE);
   localparam logic [10:0] YMAX   = 11'(SCREEN_H - BALL_SIZE);
   localparam logic [10:0] BS     = 11'(BALL_SIZE);
   localparam logic [10:0] STP    = 11'(STEP);
   localparam logic [10:0] PH     = 11'(PADDLE_H);
   localparam logic [10:0] L_FACE = 11'(PADDLE_X_L + PADDLE_W);
   localparam logic [10:0] R_FACE = 11'(PADDLE_X_R);
   localparam logic [10:0] R_STOP = 11'(PADDLE_X_R - BALL_SIZE);
   localparam logic [3:0]  WIN_M1 = 4'(WIN_SCORE - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

   state_t        state_q, state_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          dx_q, dx_d;
   logic          dy_q, dy_d;
   logic [3:0]    sl_q, sl_d, sr_q, sr_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          goal_q, goal_d;
   logic          dir_q, dir_d;
   logic          rel_q, rel_d;

   logic [10:0] x_w, y_w, pl_w, pr_w;
   logic [9:0]  x_inc, x_dec, y_inc, y_dec;
   logic        ov_l, ov_r;
   logic        hit_l, hit_r, miss_l, miss_r;

   // Collision geometry on 11-bit operands so no compare wraps
   always_comb begin
      x_w    = {1'b0, x_q};
      y_w    = {1'b0, y_q};
      pl_w   = {1'b0, paddle_l_y_i};
      pr_w   = {1'b0, paddle_r_y_i};
      x_inc  = x_q + STP[9:0];
      x_dec  = x_q - STP[9:0];
      y_inc  = y_q + STP[9:0];
      y_dec  = y_q - STP[9:0];
      ov_l   = (y_w + BS > pl_w) && (y_w < pl_w + PH);
      ov_r   = (y_w + BS > pr_w) && (y_w < pr_w + PH);
      hit_l  = !dx_q && (x_w >= L_FACE)
               && (x_w <= L_FACE + STP) && ov_l;
      miss_l = !dx_q && !hit_l && (x_w <= STP);
      hit_r  = dx_q && (x_w + BS <= R_FACE)
               && (x_w + STP + BS >= R_FACE) && ov_r;
      miss_r = dx_q && !hit_r && (x_w + STP >= XMAX);
   end

   // Next-state, motion and scoring decisions
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      sl_d    = sl_q;
      sr_d    = sr_q;
      hold_d  = hold_q;
      goal_d  = 1'b0;
      dir_d   = dir_q;
      rel_d   = rel_q & serve_i;
      case (state_q)
         IDLE: begin
            x_d = XC[9:0];
            y_d = YC[9:0];
            if (serve_i && !rel_q) begin
               state_d = PLAY;
               dx_d    = dir_q;
               dy_d    = 1'b1;
            end
         end
         PLAY: begin
            if (strobe_i) begin
               if (dy_q) begin
                  if (y_w + STP >= YMAX) begin
                     y_d  = YMAX[9:0];
                     dy_d = 1'b0;
                  end else begin
                     y_d = y_inc;
                  end
               end else begin
                  if (y_w <= STP) begin
                     y_d  = '0;
                     dy_d = 1'b1;
                  end else begin
                     y_d = y_dec;
                  end
               end
               if (hit_l) begin
                  x_d  = L_FACE[9:0];
                  dx_d = 1'b1;
               end else if (miss_l) begin
                  x_d     = '0;
                  sr_d    = sr_q + 4'd1;
                  goal_d  = 1'b1;
                  dir_d   = 1'b0;
                  hold_d  = '0;
                  state_d = (sr_q == WIN_M1) ? OVER : GOAL;
               end else if (hit_r) begin
                  x_d  = R_STOP[9:0];
                  dx_d = 1'b0;
               end else if (miss_r) begin
                  x_d     = XMAX[9:0];
                  sl_d    = sl_q + 4'd1;
                  goal_d  = 1'b1;
                  dir_d   = 1'b1;
                  hold_d  = '0;
                  state_d = (sl_q == WIN_M1) ? OVER : GOAL;
               end else if (dx_q) begin
                  x_d = x_inc;
               end else begin
                  x_d = x_dec;
               end
            end
         end
         GOAL: begin
            if (strobe_i) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d  = '0;
                  x_d     = XC[9:0];
                  y_d     = YC[9:0];
                  state_d = IDLE;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         OVER: begin
            if (serve_i) begin
               sl_d    = '0;
               sr_d    = '0;
               x_d     = XC[9:0];
               y_d     = YC[9:0];
               dir_d   = 1'b1;
               rel_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         x_q     <= XC[9:0];
         y_q     <= YC[9:0];
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         sl_q    <= '0;
         sr_q    <= '0;
         hold_q  <= '0;
         goal_q  <= 1'b0;
         dir_q   <= 1'b1;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         sl_q    <= sl_d;
         sr_q    <= sr_d;
         hold_q  <= hold_d;
         goal_q  <= goal_d;
         dir_q   <= dir_d;
         rel_q   <= rel_d;
      end
   end

   assign ball_x_o    = x_q;
   assign ball_y_o    = y_q;
   assign score_l_o   = sl_q;
   assign score_r_o   = sr_q;
   assign goal_o      = goal_q;
   assign game_over_o = (state_q == OVER);

endmodule
